// File: rtl/dp_sram_console.sv
// Dual-port byte-writable SRAM with configurable read latency and read-during-write view,
// plus a buffered "tohost" console FIFO fed by port-A writes to a fixed word.
module dp_sram_console #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned ADDR_SHIFT   = 2,
   parameter int unsigned READ_LATENCY = 1,
   parameter bit          WRITE_FIRST  = 1'b0,
   parameter int unsigned TOHOST_WORD  = 49153,
   parameter int unsigned CONS_DEPTH   = 8
) (
   input  logic                    clk_i,
   input  logic                    nreset_i,
   input  logic                    a_en_i,
   input  logic [DATA_WIDTH/8-1:0] a_we_i,
   input  logic [31:0]             a_addr_i,
   input  logic [DATA_WIDTH-1:0]   a_wdata_i,
   output logic [DATA_WIDTH-1:0]   a_rdata_o,
   output logic                    a_rvalid_o,
   input  logic                    b_en_i,
   input  logic [DATA_WIDTH/8-1:0] b_we_i,
   input  logic [31:0]             b_addr_i,
   input  logic [DATA_WIDTH-1:0]   b_wdata_i,
   output logic [DATA_WIDTH-1:0]   b_rdata_o,
   output logic                    b_rvalid_o,
   output logic [7:0]              cons_data_o,
   output logic                    cons_valid_o,
   input  logic                    cons_ready_i,
   output logic                    cons_overflow_o,
   output logic                    collision_o
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
   localparam int unsigned PtrW     = $clog2(CONS_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] TohostIdx = ADDR_WIDTH'(TOHOST_WORD);
   localparam logic [PtrW:0]         ConsFull  = (PtrW + 1)'(CONS_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [Depth];

   logic [1:0]            en;
   logic [NumBytes-1:0]   we    [2];
   logic [31:0]           word  [2];
   logic [ADDR_WIDTH-1:0] idx   [2];
   logic [DATA_WIDTH-1:0] wdata [2];
   logic [DATA_WIDTH-1:0] view  [2];
   logic [DATA_WIDTH-1:0] d1_q  [2];
   logic [DATA_WIDTH-1:0] rdata [2];
   logic [1:0]            v1_q;
   logic [1:0]            rvalid;
   logic                  unused_addr;

   assign en       = {b_en_i, a_en_i};
   assign we[0]    = a_we_i;
   assign we[1]    = b_we_i;
   assign wdata[0] = a_wdata_i;
   assign wdata[1] = b_wdata_i;
   assign word[0]  = a_addr_i >> ADDR_SHIFT;
   assign word[1]  = b_addr_i >> ADDR_SHIFT;
   assign idx[0]   = word[0][ADDR_WIDTH-1:0];
   assign idx[1]   = word[1][ADDR_WIDTH-1:0];
   assign unused_addr = ^{word[0], word[1]};

   // Each port sees only its own lanes merged; the other port always reads old data.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         view[p] = mem_q[idx[p]];
         if (WRITE_FIRST) begin
            for (int i = 0; i < NumBytes; i++) begin
               if (we[p][i]) view[p][8*i +: 8] = wdata[p][8*i +: 8];
            end
         end
      end
   end

   // Port A is written last so it wins overlapping lanes.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NumBytes; i++) begin
         if (en[1] && we[1][i]) mem_q[idx[1]][8*i +: 8] <= wdata[1][8*i +: 8];
         if (en[0] && we[0][i]) mem_q[idx[0]][8*i +: 8] <= wdata[0][8*i +: 8];
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         v1_q    <= '0;
         d1_q[0] <= '0;
         d1_q[1] <= '0;
      end else begin
         v1_q <= en;
         for (int p = 0; p < 2; p++) begin
            if (en[p]) d1_q[p] <= view[p];
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]            v2_q;
      logic [DATA_WIDTH-1:0] d2_q [2];

      always_ff @(posedge clk_i or negedge nreset_i) begin
         if (!nreset_i) begin
            v2_q    <= '0;
            d2_q[0] <= '0;
            d2_q[1] <= '0;
         end else begin
            v2_q <= v1_q;
            for (int p = 0; p < 2; p++) begin
               if (v1_q[p]) d2_q[p] <= d1_q[p];
            end
         end
      end

      assign rvalid = v2_q;
      assign rdata  = d2_q;
   end else begin : g_lat1
      assign rvalid = v1_q;
      assign rdata  = d1_q;
   end

   assign a_rdata_o  = rdata[0];
   assign b_rdata_o  = rdata[1];
   assign a_rvalid_o = rvalid[0];
   assign b_rvalid_o = rvalid[1];

   logic [7:0]  fifo_q [CONS_DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PtrW:0]   cnt_q, cnt_d;
   logic [7:0]  cons_data_q, cons_data_d;
   logic        cons_valid_q, ovf_q, coll_q;
   logic        push_req, push, pop, full, same_word_wr;

   always_comb begin
      push_req     = en[0] && we[0][0] && (idx[0] == TohostIdx);
      pop          = cons_valid_q && cons_ready_i;
      full         = (cnt_q == ConsFull);
      push         = push_req && (!full || pop);
      same_word_wr = en[0] && en[1] && (|we[0]) && (|we[1]) && (idx[0] == idx[1]);
      rptr_d       = rptr_q + PtrW'(pop);
      wptr_d       = wptr_q + PtrW'(push);
      cnt_d        = cnt_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
      // Head after the edge may be the byte being pushed right now.
      cons_data_d  = (push && (wptr_q == rptr_d)) ? a_wdata_i[7:0] : fifo_q[rptr_d];
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wptr_q] <= a_wdata_i[7:0];
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         cnt_q        <= '0;
         cons_valid_q <= 1'b0;
         cons_data_q  <= '0;
         ovf_q        <= 1'b0;
         coll_q       <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         cnt_q        <= cnt_d;
         cons_valid_q <= (cnt_d != '0);
         cons_data_q  <= cons_data_d;
         ovf_q        <= ovf_q | (push_req && full && !pop);
         coll_q       <= coll_q | same_word_wr;
      end
   end

   assign cons_data_o     = cons_data_q;
   assign cons_valid_o    = cons_valid_q;
   assign cons_overflow_o = ovf_q;
   assign collision_o     = coll_q;

endmodule
